flp_round_pipe: RTL and testbench

- Pipelined, parametrised floating-point significand rounding unit.
- Successor to the single-mode combinational rounder: adds IEEE-754 rounding modes, a sticky input, an inexact flag, a tag sideband and valid/ready flow control.
- Sits between the normalise stage and exponent adjust/pack in the FP32 add/mul datapaths.
- Outputs: rounded significand (hidden bit included) and an exponent delta for carry-out renormalisation.

---
 rtl/flp_defs.sv | 15 +
 rtl/flp_round_dec.sv | 26 ++
 rtl/flp_round_pipe.sv | 158 +++++++++++++++
 tb/tb_flp_round_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flp_defs.sv
// Shared floating-point rounding definitions: rounding-mode encodings and FP32 field widths.
package flp_defs;

    localparam int FLP_EWIDTH = 8;
    localparam int FLP_SWIDTH = 23;

    typedef enum logic [2:0] {
        FLP_RM_RNE = 3'd0,
        FLP_RM_RTZ = 3'd1,
        FLP_RM_RDN = 3'd2,
        FLP_RM_RUP = 3'd3,
        FLP_RM_RMM = 3'd4
    } flp_rmode_e;

endpackage

// File: rtl/flp_round_dec.sv
// Rounding decision: increment and inexact from the kept LSB, guard bit, rest bits, sign and mode.
module flp_round_dec
    import flp_defs::*;
(
    input  logic       i_lsb,
    input  logic       i_g,
    input  logic       i_rest,
    input  logic       i_sign,
    input  logic [2:0] i_rmode,
    output logic       o_inc,
    output logic       o_inexact
);

    always_comb begin
        o_inexact = i_g | i_rest;
        case (i_rmode)
            FLP_RM_RTZ: o_inc = 1'b0;
            FLP_RM_RDN: o_inc = i_sign & (i_g | i_rest);
            FLP_RM_RUP: o_inc = ~i_sign & (i_g | i_rest);
            FLP_RM_RMM: o_inc = i_g;
            // RNE and the unused encodings 5..7
            default:    o_inc = i_g & (i_rest | i_lsb);
        endcase
    end

endmodule

// File: rtl/flp_round_pipe.sv
// Two-stage pipelined significand rounder with valid/ready flow control and tag sideband.
// Optional saturating inexact-result counter enabled by FLP_ROUND_PIPE_INEXACT_CNT_EN.
module flp_round_pipe
    import flp_defs::*;
#(
    parameter int EWIDTH  = FLP_EWIDTH,
    parameter int SWIDTH  = FLP_SWIDTH,
    parameter int RSWIDTH = 2,
    parameter int TWIDTH  = 4,
    parameter int CWIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic [SWIDTH+RSWIDTH:0]   i_sg,
    input  logic                      i_sticky,
    input  logic                      i_sign,
    input  logic [2:0]                i_rmode,
    input  logic [TWIDTH-1:0]         i_tag,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [SWIDTH:0]           o_sg,
    output logic [EWIDTH+1:0]         o_exd,
    output logic                      o_inexact,
    output logic                      o_sign,
    output logic [TWIDTH-1:0]         o_tag
`ifdef FLP_ROUND_PIPE_INEXACT_CNT_EN
    ,
    output logic [CWIDTH-1:0]         o_inx_cnt
`endif
);

    if (RSWIDTH < 1 || CWIDTH < 1) begin : g_bad_param
        $error("flp_round_pipe: RSWIDTH and CWIDTH must be >= 1");
    end

    logic [SWIDTH:0]   w_keep;
    logic              w_g;
    logic              w_rest;
    logic              w_inc;
    logic              w_inexact;
    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_in_fire;
    logic [SWIDTH+1:0] w_sum;
    logic              w_carry;
    logic [SWIDTH:0]   w_sg_rnd;

    logic              r_s1_vld;
    logic [SWIDTH:0]   r_s1_keep;
    logic              r_s1_inc;
    logic              r_s1_inx;
    logic              r_s1_sign;
    logic [TWIDTH-1:0] r_s1_tag;

    logic              r_s2_vld;
    logic [SWIDTH:0]   r_s2_sg;
    logic              r_s2_exd;
    logic              r_s2_inx;
    logic              r_s2_sign;
    logic [TWIDTH-1:0] r_s2_tag;

    assign w_keep = i_sg[SWIDTH+RSWIDTH:RSWIDTH];
    assign w_g    = i_sg[RSWIDTH-1];

    if (RSWIDTH >= 2) begin : g_rest_bits
        assign w_rest = (|i_sg[RSWIDTH-2:0]) | i_sticky;
    end else begin : g_rest_sticky
        assign w_rest = i_sticky;
    end

    flp_round_dec u_dec (
        .i_lsb     (w_keep[0]),
        .i_g       (w_g),
        .i_rest    (w_rest),
        .i_sign    (i_sign),
        .i_rmode   (i_rmode),
        .o_inc     (w_inc),
        .o_inexact (w_inexact)
    );

    assign w_s2_adv  = ~r_s2_vld | i_rdy;
    assign w_s1_adv  = ~r_s1_vld | w_s2_adv;
    assign o_rdy     = w_s1_adv;
    assign w_in_fire = i_vld & w_s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_keep <= '0;
            r_s1_inc  <= 1'b0;
            r_s1_inx  <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_tag  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_vld <= i_vld;
            end
            if (w_in_fire) begin
                r_s1_keep <= w_keep;
                r_s1_inc  <= w_inc;
                r_s1_inx  <= w_inexact;
                r_s1_sign <= i_sign;
                r_s1_tag  <= i_tag;
            end
        end
    end

    // A carry out of the kept field can only come from all-ones + 1, so the shifted result is 100..0.
    assign w_sum    = {1'b0, r_s1_keep} + {{(SWIDTH+1){1'b0}}, r_s1_inc};
    assign w_carry  = w_sum[SWIDTH+1];
    assign w_sg_rnd = w_carry ? w_sum[SWIDTH+1:1] : w_sum[SWIDTH:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_sg   <= '0;
            r_s2_exd  <= 1'b0;
            r_s2_inx  <= 1'b0;
            r_s2_sign <= 1'b0;
            r_s2_tag  <= '0;
        end else begin
            if (w_s2_adv) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_s2_adv && r_s1_vld) begin
                r_s2_sg   <= w_sg_rnd;
                r_s2_exd  <= w_carry;
                r_s2_inx  <= r_s1_inx;
                r_s2_sign <= r_s1_sign;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    assign o_vld     = r_s2_vld;
    assign o_sg      = r_s2_sg;
    assign o_exd     = {{(EWIDTH+1){1'b0}}, r_s2_exd};
    assign o_inexact = r_s2_inx;
    assign o_sign    = r_s2_sign;
    assign o_tag     = r_s2_tag;

`ifdef FLP_ROUND_PIPE_INEXACT_CNT_EN
    logic [CWIDTH-1:0] r_inx_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inx_cnt <= '0;
        end else if (r_s2_vld && i_rdy && r_s2_inx && !(&r_inx_cnt)) begin
            r_inx_cnt <= r_inx_cnt + CWIDTH'(1);
        end
    end

    assign o_inx_cnt = r_inx_cnt;
`endif

endmodule

// File: tb/tb_flp_round_pipe.sv
// Directed bench for flp_round_pipe: vector table, stalled stream, mid-stream reset, optional counter.
module tb_flp_round_pipe;

    localparam int EW  = 8;
    localparam int SW  = 23;
    localparam int RSW = 2;
    localparam int TW  = 4;
    localparam int CW  = 2;

    logic              clk;
    logic              rst;
    logic              i_vld;
    logic              o_rdy;
    logic [SW+RSW:0]   i_sg;
    logic              i_sticky;
    logic              i_sign;
    logic [2:0]        i_rmode;
    logic [TW-1:0]     i_tag;
    logic              o_vld;
    logic              i_rdy;
    logic [SW:0]       o_sg;
    logic [EW+1:0]     o_exd;
    logic              o_inexact;
    logic              o_sign;
    logic [TW-1:0]     o_tag;
`ifdef FLP_ROUND_PIPE_INEXACT_CNT_EN
    logic [CW-1:0]     o_inx_cnt;
`endif

    flp_round_pipe #(
        .EWIDTH (EW),
        .SWIDTH (SW),
        .RSWIDTH(RSW),
        .TWIDTH (TW),
        .CWIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (i_vld),
        .o_rdy     (o_rdy),
        .i_sg      (i_sg),
        .i_sticky  (i_sticky),
        .i_sign    (i_sign),
        .i_rmode   (i_rmode),
        .i_tag     (i_tag),
        .o_vld     (o_vld),
        .i_rdy     (i_rdy),
        .o_sg      (o_sg),
        .o_exd     (o_exd),
        .o_inexact (o_inexact),
        .o_sign    (o_sign),
        .o_tag     (o_tag)
`ifdef FLP_ROUND_PIPE_INEXACT_CNT_EN
        ,
        .o_inx_cnt (o_inx_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [25:0] sg;
        logic        sticky;
        logic        sign;
        logic [2:0]  rm;
        logic [23:0] e_sg;
        logic        e_exd;
        logic        e_inx;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_in(input vec_t v, input logic [TW-1:0] tag);
        i_sg     = v.sg;
        i_sticky = v.sticky;
        i_sign   = v.sign;
        i_rmode  = v.rm;
        i_tag    = tag;
    endtask

    task automatic check_out(input string nm, input vec_t v, input logic [TW-1:0] tag);
        check({nm, "_vld"}, 32'(o_vld), 32'd1);
        check({nm, "_sg"}, 32'(o_sg), 32'(v.e_sg));
        check({nm, "_exd"}, 32'(o_exd), 32'(v.e_exd));
        check({nm, "_inx"}, 32'(o_inexact), 32'(v.e_inx));
        check({nm, "_sign"}, 32'(o_sign), 32'(v.sign));
        check({nm, "_tag"}, 32'(o_tag), 32'(tag));
    endtask

    // One isolated transaction: accept, confirm 2-cycle latency, compare, drain on next edge.
    task automatic run_vec(input vec_t v, input logic [TW-1:0] tag, input string nm);
        int n;
        @(negedge clk);
        drive_in(v, tag);
        i_vld = 1'b1;
        i_rdy = 1'b1;
        #1;
        check({nm, "_ordy"}, 32'(o_rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        i_vld = 1'b0;
        check({nm, "_lat1"}, 32'(o_vld), 32'd0);
        @(negedge clk);
        n = 0;
        while (!o_vld && n < 4) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_lat2"}, 32'(n), 32'd0);
        check_out(nm, v, tag);
    endtask

    initial begin
        int sent;
        int got;
        logic prev_stall;
        logic saw_ordy_low;
        logic [SW:0]   snap_sg;
        logic [TW-1:0] snap_tag;

        //               sg            stk   sign  rm    e_sg          exd   inx
        vecs[0]  = '{26'h0000003, 1'b0, 1'b0, 3'd0, 24'h000001, 1'b0, 1'b1};
        vecs[1]  = '{26'h0000002, 1'b0, 1'b0, 3'd0, 24'h000000, 1'b0, 1'b1};
        vecs[2]  = '{26'h0000006, 1'b0, 1'b0, 3'd0, 24'h000002, 1'b0, 1'b1};
        vecs[3]  = '{26'h3ffffff, 1'b0, 1'b0, 3'd0, 24'h800000, 1'b1, 1'b1};
        vecs[4]  = '{26'h3ffffff, 1'b0, 1'b0, 3'd1, 24'hffffff, 1'b0, 1'b1};
        vecs[5]  = '{26'h0000001, 1'b0, 1'b1, 3'd2, 24'h000001, 1'b0, 1'b1};
        vecs[6]  = '{26'h0000001, 1'b0, 1'b0, 3'd2, 24'h000000, 1'b0, 1'b1};
        vecs[7]  = '{26'h0000001, 1'b0, 1'b0, 3'd4, 24'h000000, 1'b0, 1'b1};
        vecs[8]  = '{26'h0000002, 1'b1, 1'b0, 3'd0, 24'h000001, 1'b0, 1'b1};
        vecs[9]  = '{26'h0000001, 1'b0, 1'b0, 3'd3, 24'h000001, 1'b0, 1'b1};
        vecs[10] = '{26'h0000001, 1'b0, 1'b1, 3'd3, 24'h000000, 1'b0, 1'b1};
        vecs[11] = '{26'h0000002, 1'b0, 1'b0, 3'd4, 24'h000001, 1'b0, 1'b1};
        vecs[12] = '{26'h0000002, 1'b0, 1'b0, 3'd7, 24'h000000, 1'b0, 1'b1};
        vecs[13] = '{26'h0000004, 1'b0, 1'b0, 3'd3, 24'h000001, 1'b0, 1'b0};
        vecs[14] = '{26'h3fffffc, 1'b0, 1'b0, 3'd3, 24'hffffff, 1'b0, 1'b0};
        vecs[15] = '{26'h3fffffd, 1'b0, 1'b1, 3'd2, 24'h800000, 1'b1, 1'b1};
        vecs[16] = '{26'h0000006, 1'b0, 1'b0, 3'd5, 24'h000002, 1'b0, 1'b1};

        rst      = 1'b1;
        i_vld    = 1'b0;
        i_rdy    = 1'b1;
        i_sg     = '0;
        i_sticky = 1'b0;
        i_sign   = 1'b0;
        i_rmode  = 3'd0;
        i_tag    = '0;
        #12;
        check("rst_vld", 32'(o_vld), 32'd0);
        check("rst_sg", 32'(o_sg), 32'd0);
        check("rst_exd", 32'(o_exd), 32'd0);
        check("rst_inx", 32'(o_inexact), 32'd0);
        check("rst_sign", 32'(o_sign), 32'd0);
        check("rst_tag", 32'(o_tag), 32'd0);
        check("rst_ordy", 32'(o_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], TW'(i), $sformatf("vec%0d", i));
        end

        // Back-to-back stream of 6 with downstream stalled for cycles 3..5
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        saw_ordy_low = 1'b0;
        snap_sg = '0;
        snap_tag = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            i_rdy = !(c >= 3 && c <= 5);
            if (sent < 6) begin
                drive_in(vecs[sent], TW'(sent));
                i_vld = 1'b1;
            end else begin
                i_vld = 1'b0;
            end
            #1;
            check("strm_ordy", 32'(o_rdy), 32'(!((sent - got) == 2 && !i_rdy)));
            if (!o_rdy) saw_ordy_low = 1'b1;
            if (prev_stall) begin
                check("strm_hold_vld", 32'(o_vld), 32'd1);
                check("strm_hold_sg", 32'(o_sg), 32'(snap_sg));
                check("strm_hold_tag", 32'(o_tag), 32'(snap_tag));
            end
            if (o_vld && i_rdy) begin
                check("strm_tag", 32'(o_tag), 32'(got));
                check("strm_sg", 32'(o_sg), 32'(vecs[got].e_sg));
                check("strm_exd", 32'(o_exd), 32'(vecs[got].e_exd));
                got++;
            end
            prev_stall = o_vld && !i_rdy;
            snap_sg = o_sg;
            snap_tag = o_tag;
            if (i_vld && o_rdy) sent++;
        end
        @(negedge clk);
        i_vld = 1'b0;
        i_rdy = 1'b1;
        check("strm_got", 32'(got), 32'd6);
        check("strm_sent", 32'(sent), 32'd6);
        check("strm_ordy_dropped", 32'(saw_ordy_low), 32'd1);
        #1;
        check("strm_empty", 32'(o_vld), 32'd0);

        // Reset with two entries in flight
        @(negedge clk);
        drive_in(vecs[0], 4'hA);
        i_vld = 1'b1;
        i_rdy = 1'b0;
        @(negedge clk);
        drive_in(vecs[3], 4'hB);
        @(negedge clk);
        i_vld = 1'b0;
        check("full_vld", 32'(o_vld), 32'd1);
        check("full_ordy", 32'(o_rdy), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_vld", 32'(o_vld), 32'd0);
        check("midrst_sg", 32'(o_sg), 32'd0);
        check("midrst_tag", 32'(o_tag), 32'd0);
        check("midrst_inx", 32'(o_inexact), 32'd0);
        check("midrst_ordy", 32'(o_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        i_rdy = 1'b1;
        run_vec(vecs[2], 4'h9, "post_rst");
        @(negedge clk);
        check("post_rst_drain", 32'(o_vld), 32'd0);

`ifdef FLP_ROUND_PIPE_INEXACT_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("cnt_rst", 32'(o_inx_cnt), 32'd0);
        run_vec(vecs[0], 4'h1, "cnt_a");
        run_vec(vecs[1], 4'h2, "cnt_b");
        @(negedge clk);
        check("cnt_two", 32'(o_inx_cnt), 32'd2);
        run_vec(vecs[2], 4'h3, "cnt_c");
        run_vec(vecs[3], 4'h4, "cnt_d");
        run_vec(vecs[4], 4'h5, "cnt_e");
        @(negedge clk);
        check("cnt_sat", 32'(o_inx_cnt), 32'd3);
        run_vec(vecs[13], 4'h6, "cnt_exact");
        @(negedge clk);
        check("cnt_exact_hold", 32'(o_inx_cnt), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
